// File: rtl/serv_bufreg_nw_if.sv
// Bundle of the buffer register's control, operand and result signals.
// The master drives a pass; the slave (the buffer register) returns the shifted results.
interface serv_bufreg_nw_if #(
    parameter int W = 1
);
    logic         i_en;
    logic         i_init;
    logic         i_cnt0;
    logic         i_rs1_en;
    logic         i_imm_en;
    logic         i_clr_lsb;
    logic         i_sh_signed;
    logic         i_mdu_op;
    logic [W-1:0] i_rs1;
    logic [W-1:0] i_imm;
    logic [W-1:0] o_q;
    logic [1:0]   o_lsb;
    logic         o_last;
    logic [31:0]  o_dbus_adr;
    logic [31:0]  o_ext_rs1;

    modport master (
        output i_en, i_init, i_cnt0, i_rs1_en, i_imm_en, i_clr_lsb,
               i_sh_signed, i_mdu_op, i_rs1, i_imm,
        input  o_q, o_lsb, o_last, o_dbus_adr, o_ext_rs1
    );

    modport slave (
        input  i_en, i_init, i_cnt0, i_rs1_en, i_imm_en, i_clr_lsb,
               i_sh_signed, i_mdu_op, i_rs1, i_imm,
        output o_q, o_lsb, o_last, o_dbus_adr, o_ext_rs1
    );
endinterface

// File: rtl/serv_bufreg_nw.sv
// W-bit-per-cycle 32-bit buffer register: serial address add (init pass) and
// logical/arithmetic right shift (shift pass), with latched address LSBs.
module serv_bufreg_nw #(
    parameter int W   = 1,
    parameter int MDU = 0
) (
    input logic             i_clk,
    input logic             i_rst,
    serv_bufreg_nw_if.slave bus
);
    localparam int            NCHUNK   = 32 / W;
    localparam int            CW       = $clog2(NCHUNK);
    localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

    logic [31:0]   data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_q, c_d;
    logic [1:0]    lsb_q, lsb_d;
    logic          last;
    logic [W-1:0]  rs1_g, imm_g, clr_v;
    logic [W:0]    sum;

    always_comb begin
        last  = bus.i_en & (cnt_q == CNT_LAST);
        // Only bit 0 of the first immediate chunk is cleared (jalr target alignment).
        clr_v = W'(bus.i_cnt0 & bus.i_clr_lsb);
        rs1_g = bus.i_rs1 & {W{bus.i_rs1_en}};
        imm_g = bus.i_imm & {W{bus.i_imm_en}} & ~clr_v;
        sum   = {1'b0, rs1_g} + {1'b0, imm_g} + {{W{1'b0}}, c_q};

        // Carry never survives the last chunk or an idle cycle, so passes stay independent.
        c_d   = bus.i_en & ~last & sum[W];
        cnt_d = bus.i_en ? cnt_q + 1'b1 : '0;

        data_d = data_q;
        lsb_d  = lsb_q;
        if (bus.i_en) begin
            if (bus.i_init) begin
                data_d = {sum[W-1:0], data_q[31:W]};
            end else begin
                data_d = {{W{data_q[31] & bus.i_sh_signed}}, data_q[31:W]};
            end
        end
        if (last & bus.i_init) begin
            lsb_d = data_d[1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= '0;
            cnt_q  <= '0;
            c_q    <= 1'b0;
            lsb_q  <= 2'b00;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            c_q    <= c_d;
            lsb_q  <= lsb_d;
        end
    end

    always_comb begin
        bus.o_q        = bus.i_en ? data_q[W-1:0] : '0;
        bus.o_lsb      = ((MDU != 0) && bus.i_mdu_op) ? 2'b00 : lsb_q;
        bus.o_last     = last;
        bus.o_dbus_adr = {data_q[31:2], 2'b00};
        bus.o_ext_rs1  = data_q;
    end
endmodule

// File: doc/serv_bufreg_nw.md
SERV_BUFREG_NW -- requirements
Module: serv_bufreg_nw

Interface -- parameters
REQ-001 SHALL provide parameter W, default 1, meaning datapath chunk width in bits; legal values 1, 2, 4, 8.
REQ-002 SHALL provide parameter MDU, default 0, meaning 1 = multiply/divide extension present.

Interface -- ports
REQ-003 SHALL provide i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL provide i_en, input, 1, pass active (one chunk per cycle).
REQ-006 SHALL provide i_init, input, 1, 1 = address-compute pass, 0 = shift-out pass.
REQ-007 SHALL provide i_cnt0, input, 1, first chunk of pass.
REQ-008 SHALL provide i_rs1_en, i_imm_en, i_clr_lsb, i_sh_signed, i_mdu_op, inputs, 1 each, operand gates, jalr LSB clear, arithmetic fill, MDU op.
REQ-009 SHALL provide i_rs1, i_imm, inputs, W each, operand chunks, LSB chunk first.
REQ-010 SHALL provide o_q, output, W, current low chunk of buffer.
REQ-011 SHALL provide o_lsb, output, 2, latched address bits [1:0].
REQ-012 SHALL provide o_last, output, 1, high on final chunk cycle of a pass.
REQ-013 SHALL provide o_dbus_adr, output, 32, {data[31:2],2'b00}; o_ext_rs1, output, 32, full buffer.

Function
REQ-014 Chunk sum SHALL be {c,q} = (i_rs1 & rs1_en) + (i_imm & imm_en & ~clr) + c_r, where clr masks only bit 0 and only when i_cnt0 & i_clr_lsb.
REQ-015 Carry c_r SHALL register c when i_en and not o_last; SHALL be 0 otherwise (no carry leaks between passes; carry out of bit 31 discarded).
REQ-016 Internal counter cnt (log2(32/W) bits) SHALL increment on each i_en cycle, wrap from 32/W-1 to 0, and clear to 0 on any cycle with i_en low.
REQ-017 o_last SHALL equal i_en & (cnt == 32/W-1), combinational.
REQ-018 Init pass (i_en & i_init): data SHALL shift right by W with q entering data[31:32-W]; after 32/W cycles data holds the 32-bit sum.
REQ-019 Shift pass (i_en & ~i_init): data SHALL shift right by W with W copies of (data[31] & i_sh_signed) entering the top.
REQ-020 i_en low: data SHALL hold its value (o_dbus_adr stable between passes).
REQ-021 lsb register SHALL capture the post-shift data[1:0] on the o_last cycle of an init pass and hold otherwise.
REQ-022 o_lsb SHALL be 2'b00 when MDU & i_mdu_op, else lsb.
REQ-023 o_q SHALL be data[W-1:0] when i_en, else 0.
REQ-024 i_en dropping mid-pass SHALL abort: cnt and c_r cleared next cycle, data keeps partial value, lsb unchanged.
REQ-025 i_cnt0 SHALL only affect LSB masking; pass alignment comes from cnt.

Reset
REQ-026 i_rst high SHALL clear data, c_r, cnt, lsb to 0 next edge, overriding i_en; outputs then o_q=0, o_lsb=0, o_last=0, o_dbus_adr=0, o_ext_rs1=0.
REQ-027 Reset asserted mid-pass SHALL discard the pass; first i_en cycle after release is chunk 0.

Verification
REQ-028 W=1, init pass, rs1=0x00001000, imm=0x00000FFE, both enabled, 32 cycles -> o_dbus_adr=0x00001FFC, o_lsb=2'b10, o_last high only on cycle 32.
REQ-029 W=4, same operands, 8 cycles -> identical o_dbus_adr/o_lsb; o_last on cycle 8; c_r=0 afterwards.
REQ-030 W=1, jalr: rs1=0x00000100, imm=0x00000003, i_clr_lsb, i_cnt0 on cycle 1 -> o_ext_rs1=0x00000102.
REQ-031 W=4, buffer 0x80000000, shift pass with i_sh_signed=1, 2 cycles -> o_ext_rs1=0xFF800000; with i_sh_signed=0 -> 0x00800000.
REQ-032 W=8, rs1=0xFFFFFFFF, imm=0x00000001, init pass -> o_ext_rs1=0; immediate second pass rs1=0, imm=0 -> 0 (no carry leak).
REQ-033 i_rst pulsed on cycle 3 of a W=2 init pass, then MDU=1 with i_mdu_op=1 -> all state 0; o_lsb=2'b00 regardless of data.
